usb_tx_arbiter: RTL and testbench

- Sequencing and arbitration front-end for usb_transmitter.
- Accepts handshake requests (ACK/NAK/STALL) from the receive-side protocol logic and data-packet requests from the AHB-side endpoint logic.
- Grants one request at a time and drives a one-cycle tx_packet command to the transmitter, then tracks tx_transfer_active/tx_error through packet completion.
- Owns the DATA0/DATA1 toggle bit.

---
 rtl/usb_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_usb_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: arbitrates handshake/data requests into one-cycle tx_packet commands,
// tracks each packet to completion and owns the DATA0/DATA1 toggle. Define
// USB_TX_ARB_RETRY_EN to enable automatic reissue of failed data packets.
module usb_tx_arbiter #(
    parameter int START_TIMEOUT = 16,
    parameter int CNT_W         = 8
`ifdef USB_TX_ARB_RETRY_EN
    ,
    parameter int MAX_RETRY     = 2
`endif
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [1:0] hs_type,
    output logic       hs_grant,
    input  logic       data_req,
    output logic       data_grant,
    input  logic       data_ack_rcvd,
    input  logic       toggle_reset,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic [3:0] tx_packet,
    output logic       busy,
    output logic       xfer_done,
    output logic       xfer_err,
    output logic       cur_toggle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_ACTIVE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [3:0] PID_NONE  = 4'd0;
    localparam logic [3:0] PID_DATA0 = 4'd1;
    localparam logic [3:0] PID_DATA1 = 4'd2;
    localparam logic [3:0] PID_ACK   = 4'd3;
    localparam logic [3:0] PID_NAK   = 4'd4;
    localparam logic [3:0] PID_STALL = 4'd5;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic             src_hs_q, src_hs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             toggle_q, toggle_d;
    logic             last_ok_q, last_ok_d;
    logic             last_data_q, last_data_d;
    logic             retry_now;
    logic             first_issue;

`ifdef USB_TX_ARB_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    logic [RW-1:0] retry_q, retry_d;

    // Only the attempt that follows a fresh grant pulses the grant output.
    assign first_issue = (retry_q == '0);
`else
    assign first_issue = 1'b1;
`endif

    function automatic logic [3:0] hs_pid(input logic [1:0] t);
        case (t)
            2'd0:    return PID_ACK;
            2'd2:    return PID_STALL;
            default: return PID_NAK;
        endcase
    endfunction

    // Toggle bookkeeping: last_ok/last_data describe the most recently finished packet.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        toggle_d    = toggle_q;
        last_ok_d   = last_ok_q;
        last_data_d = last_data_q;
        if (state_q == S_DONE) begin
            last_ok_d   = 1'b1;
            last_data_d = !src_hs_q;
        end else if (state_q == S_ERR) begin
            last_ok_d   = 1'b0;
            last_data_d = !src_hs_q;
        end
        // An endpoint reset also discards any pending acknowledge of the old packet.
        if (toggle_reset) begin
            toggle_d  = 1'b0;
            last_ok_d = 1'b0;
        end else if (data_ack_rcvd && state_q == S_IDLE && last_ok_q && last_data_q) begin
            toggle_d  = !toggle_q;
            last_ok_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pid_d     = pid_q;
        src_hs_d  = src_hs_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        retry_now = 1'b0;
`ifdef USB_TX_ARB_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hs_req) begin
                    pid_d    = hs_pid(hs_type);
                    src_hs_d = 1'b1;
                    state_d  = S_ISSUE;
`ifdef USB_TX_ARB_RETRY_EN
                    retry_d  = '0;
`endif
                end else if (data_req) begin
                    // Use the post-update toggle so an ack or reset landing this cycle counts.
                    pid_d    = toggle_d ? PID_DATA1 : PID_DATA0;
                    src_hs_d = 1'b0;
                    state_d  = S_ISSUE;
`ifdef USB_TX_ARB_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_transfer_active) begin
                    // An error seen together with the start still fails the packet.
                    err_d   = tx_error;
                    state_d = S_ACTIVE;
                end else if (tx_error || cnt_q == TIMEOUT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_ACTIVE: begin
                if (!tx_transfer_active) begin
                    state_d = (err_q || tx_error) ? S_ERR : S_DONE;
                end else begin
                    err_d = err_q | tx_error;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                state_d = S_IDLE;
`ifdef USB_TX_ARB_RETRY_EN
                if (!src_hs_q && retry_q < RETRY_LAST) begin
                    retry_d   = retry_q + RW'(1);
                    retry_now = 1'b1;
                    state_d   = S_ISSUE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            pid_q       <= PID_NONE;
            src_hs_q    <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            toggle_q    <= 1'b0;
            last_ok_q   <= 1'b0;
            last_data_q <= 1'b0;
`ifdef USB_TX_ARB_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples
            // the pre-edge values, independent of statement order.
            state_q     <= state_d;
            pid_q       <= pid_d;
            src_hs_q    <= src_hs_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            toggle_q    <= toggle_d;
            last_ok_q   <= last_ok_d;
            last_data_q <= last_data_d;
`ifdef USB_TX_ARB_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Outputs decode the registered state only, so reset clears them immediately.
    assign tx_packet  = (state_q == S_ISSUE) ? pid_q : PID_NONE;
    assign hs_grant   = (state_q == S_ISSUE) && src_hs_q && first_issue;
    assign data_grant = (state_q == S_ISSUE) && !src_hs_q && first_issue;
    assign busy       = (state_q != S_IDLE);
    assign xfer_done  = (state_q == S_DONE);
    assign xfer_err   = (state_q == S_ERR) && !retry_now;
    assign cur_toggle = toggle_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Testbench for usb_tx_arbiter: directed vector table, hand-written corner sequences
// and randomized packets checked against a transaction-level latency/toggle model.
module tb_usb_tx_arbiter;

    localparam int START_TIMEOUT = 16;
`ifdef USB_TX_ARB_RETRY_EN
    localparam int RETRY_N = 2;
`else
    localparam int RETRY_N = 0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       hs_req, data_req, data_ack_rcvd, toggle_reset;
    logic [1:0] hs_type;
    logic       tx_transfer_active, tx_error;
    logic       hs_grant, data_grant, busy, xfer_done, xfer_err, cur_toggle;
    logic [3:0] tx_packet;

    always #5 clk = ~clk;

    usb_tx_arbiter dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .hs_req             (hs_req),
        .hs_type            (hs_type),
        .hs_grant           (hs_grant),
        .data_req           (data_req),
        .data_grant         (data_grant),
        .data_ack_rcvd      (data_ack_rcvd),
        .toggle_reset       (toggle_reset),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .tx_packet          (tx_packet),
        .busy               (busy),
        .xfer_done          (xfer_done),
        .xfer_err           (xfer_err),
        .cur_toggle         (cur_toggle)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observations of one run_xfer call.
    int         iss_cyc [8];
    logic [3:0] iss_pid [8];
    logic       iss_hg  [8];
    logic       iss_dg  [8];
    int         end_cyc [4];
    logic       end_ok  [4];
    int         n_iss, n_end, n_hg, n_dg;
    logic       busy_bad, timed_out;

    // Raises the requests at cycle 0 and plays a transmitter that repeats the same script
    // relative to every observed command: active during rel [1+d, d+len], error at err_rel.
    task automatic run_xfer(input logic hs_en, input logic [1:0] htype, input logic data_en,
                            input logic has_act, input int d, input int len, input int err_rel,
                            input int ends_wanted);
        int   cyc, last_iss, rel;
        logic in_pkt;
        n_iss = 0; n_end = 0; n_hg = 0; n_dg = 0;
        busy_bad = 1'b0; in_pkt = 1'b0;
        cyc = 0; last_iss = -1000;
        hs_type = htype; hs_req = hs_en; data_req = data_en;
        while (n_end < ends_wanted && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (tx_packet != 4'd0) begin
                if (n_iss < 8) begin
                    iss_cyc[n_iss] = cyc;
                    iss_pid[n_iss] = tx_packet;
                    iss_hg[n_iss]  = hs_grant;
                    iss_dg[n_iss]  = data_grant;
                end
                n_iss++;
                last_iss = cyc;
                in_pkt   = 1'b1;
            end
            if (in_pkt && !busy) busy_bad = 1'b1;
            if (hs_grant)   begin n_hg++; hs_req = 1'b0;   end
            if (data_grant) begin n_dg++; data_req = 1'b0; end
            if (xfer_done || xfer_err) begin
                if (n_end < 4) begin
                    end_cyc[n_end] = cyc;
                    end_ok[n_end]  = xfer_done && !xfer_err;
                end
                n_end++;
                in_pkt = 1'b0;
            end
            rel = cyc - last_iss;
            tx_transfer_active = has_act && rel >= 1 + d && rel <= d + len;
            tx_error           = (err_rel != 0) && rel == err_rel;
        end
        timed_out = (n_end < ends_wanted);
        hs_req = 1'b0; data_req = 1'b0; tx_transfer_active = 1'b0; tx_error = 1'b0;
    endtask

    // Steps into the IDLE cycle after the packet and applies toggle-side pulses.
    task automatic post_actions(input int n_ack, input logic treset);
        @(posedge clk); #1;
        data_ack_rcvd = (n_ack > 0);
        toggle_reset  = treset;
        @(posedge clk); #1;
        data_ack_rcvd = (n_ack > 1);
        toggle_reset  = 1'b0;
        @(posedge clk); #1;
        data_ack_rcvd = 1'b0;
    endtask

    task automatic check_xfer(input string nm, input logic exp_hs, input logic [3:0] exp_pid,
                              input logic exp_ok, input int exp_f, input int exp_att);
        int bad_pid;
        check({nm, " finished"}, timed_out, 1'b0);
        if (!timed_out && n_iss > 0 && n_iss <= 8) begin
            bad_pid = 0;
            for (int i = 0; i < n_iss; i++) if (iss_pid[i] != exp_pid) bad_pid++;
            check({nm, " issue latency"}, iss_cyc[0], 1);
            check({nm, " pid"}, iss_pid[0], exp_pid);
            check({nm, " reissue pid"}, bad_pid, 0);
            check({nm, " grant kind"}, {iss_hg[0], iss_dg[0]}, {exp_hs, !exp_hs});
            check({nm, " grant count"}, n_hg + n_dg, 1);
            check({nm, " attempts"}, n_iss, exp_att);
            check({nm, " outcome ok"}, end_ok[0], exp_ok);
            check({nm, " end latency"}, end_cyc[0] - iss_cyc[n_iss-1], exp_f);
            check({nm, " busy held"}, busy_bad, 1'b0);
        end else begin
            check({nm, " issue count"}, n_iss, exp_att);
        end
    endtask

    // Transaction-level model: PID mapping and end latency derived from the timing rules.
    function automatic void model_xfer(input logic is_hs, input logic [1:0] htype, input logic tog,
                                       input logic has_act, input int d, input int len,
                                       input int err_rel, output logic [3:0] pid,
                                       output logic ok, output int f, output int att);
        if (is_hs) pid = (htype == 2'd0) ? 4'd3 : (htype == 2'd2) ? 4'd5 : 4'd4;
        else       pid = tog ? 4'd2 : 4'd1;
        if (has_act) begin
            f  = 2 + d + len;
            ok = (err_rel == 0);
        end else if (err_rel != 0) begin
            f  = err_rel + 1;
            ok = 1'b0;
        end else begin
            f  = START_TIMEOUT + 1;
            ok = 1'b0;
        end
        att = (!ok && !is_hs) ? 1 + RETRY_N : 1;
    endfunction

    typedef struct {
        logic       is_hs;
        logic [1:0] htype;
        logic       has_act;
        int         d, len, err_rel, n_ack;
        logic       treset;
        logic [3:0] exp_pid;
        logic       exp_ok;
        int         exp_f, exp_att;
        logic       exp_tog;
    } vec_t;

    function automatic vec_t mk(input logic is_hs, input logic [1:0] htype, input logic has_act,
                                input int d, input int len, input int err_rel, input int n_ack,
                                input logic treset, input logic [3:0] pid, input logic ok,
                                input int f, input int att, input logic tog);
        vec_t v;
        v.is_hs = is_hs; v.htype = htype; v.has_act = has_act; v.d = d; v.len = len;
        v.err_rel = err_rel; v.n_ack = n_ack; v.treset = treset; v.exp_pid = pid;
        v.exp_ok = ok; v.exp_f = f; v.exp_att = att; v.exp_tog = tog;
        return v;
    endfunction

    logic m_tog;
    logic m_ack_ok;

    task automatic random_phase();
        logic       is_hs, has_act, ok, treset;
        logic [1:0] htype;
        logic [3:0] pid;
        int         mode, d, len, err_rel, f, att, n_ack;
        for (int t = 0; t < 40; t++) begin
            is_hs   = ($urandom_range(0, 2) == 0);
            htype   = 2'($urandom_range(0, 3));
            mode    = $urandom_range(0, 5);
            d       = $urandom_range(0, START_TIMEOUT - 1);
            len     = $urandom_range(1, 6);
            has_act = (mode <= 3);
            err_rel = (mode == 3) ? $urandom_range(1 + d, d + len) :
                      (mode == 5) ? $urandom_range(1, START_TIMEOUT - 1) : 0;
            model_xfer(is_hs, htype, m_tog, has_act, d, len, err_rel, pid, ok, f, att);
            run_xfer(is_hs, htype, !is_hs, has_act, d, len, err_rel, 1);
            check_xfer($sformatf("rand%0d", t), is_hs, pid, ok, f, att);
            m_ack_ok = ok && !is_hs;
            treset   = ($urandom_range(0, 7) == 0);
            n_ack    = treset ? 0 : $urandom_range(0, 2);
            post_actions(n_ack, treset);
            if (treset) m_tog = 1'b0;
            for (int a = 0; a < n_ack; a++) begin
                if (m_ack_ok) begin
                    m_tog    = !m_tog;
                    m_ack_ok = 1'b0;
                end
            end
            check($sformatf("rand%0d toggle", t), cur_toggle, m_tog);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic reset_test();
        int   k;
        logic seen;
        if (!m_tog) begin
            run_xfer(1'b0, 2'd0, 1'b1, 1'b1, 0, 2, 0, 1);
            post_actions(1, 1'b0);
            m_tog = 1'b1;
        end
        check("rst pre toggle", cur_toggle, m_tog);
        data_req = 1'b1;
        seen = 1'b0; k = 0;
        while (!seen && k < 5) begin @(posedge clk); #1; k++; seen = data_grant; end
        check("rst first grant", seen, 1'b1);
        data_req = 1'b0;
        tx_transfer_active = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst busy in active", busy, 1'b1);
        data_req = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        check("rst async tx_packet", tx_packet, 4'd0);
        check("rst async busy", busy, 1'b0);
        check("rst async toggle", cur_toggle, 1'b0);
        check("rst async pulses", {xfer_done, xfer_err, hs_grant, data_grant}, 4'd0);
        tx_transfer_active = 1'b0;
        @(posedge clk); #1;
        check("rst held busy", busy, 1'b0);
        #2 n_rst = 1'b1;
        seen = 1'b0; k = 0;
        while (!seen && k < 5) begin @(posedge clk); #1; k++; seen = data_grant; end
        check("rst regrant latency", k, 1);
        check("rst regrant pid", tx_packet, 4'd1);
        data_req = 1'b0;
        k = 0;
        while (busy && k < 60) begin @(posedge clk); #1; k++; end
        check("rst drain idle", busy, 1'b0);
    endtask

    vec_t vecs [12];

    initial begin
        n_rst = 1'b0;
        hs_req = 1'b0; hs_type = 2'd0; data_req = 1'b0;
        data_ack_rcvd = 1'b0; toggle_reset = 1'b0;
        tx_transfer_active = 1'b0; tx_error = 1'b0;

        vecs[0]  = mk(0, 0, 1,  0, 20, 0, 1, 0, 4'd1, 1, 22, 1,           1);
        vecs[1]  = mk(0, 0, 1,  2,  4, 0, 0, 0, 4'd2, 1,  8, 1,           1);
        vecs[2]  = mk(0, 0, 1,  1,  6, 3, 1, 0, 4'd2, 0,  9, 1 + RETRY_N, 1);
        vecs[3]  = mk(1, 0, 1,  1,  3, 0, 1, 0, 4'd3, 1,  6, 1,           1);
        vecs[4]  = mk(0, 0, 0,  0,  0, 0, 1, 0, 4'd2, 0, 17, 1 + RETRY_N, 1);
        vecs[5]  = mk(1, 3, 1,  0,  2, 0, 0, 1, 4'd4, 1,  4, 1,           0);
        vecs[6]  = mk(0, 0, 1,  3,  2, 0, 1, 1, 4'd1, 1,  7, 1,           0);
        vecs[7]  = mk(0, 0, 1,  0,  1, 0, 1, 0, 4'd1, 1,  3, 1,           1);
        vecs[8]  = mk(1, 1, 0,  0,  0, 4, 0, 0, 4'd4, 0,  5, 1,           1);
        vecs[9]  = mk(1, 2, 1, 15,  2, 0, 0, 0, 4'd5, 1, 19, 1,           1);
        vecs[10] = mk(0, 0, 1, 15,  3, 0, 1, 0, 4'd2, 1, 20, 1,           0);
        vecs[11] = mk(0, 0, 1,  0,  2, 0, 2, 0, 4'd1, 1,  4, 1,           1);

        repeat (3) @(posedge clk);
        #1;
        check("reset tx_packet", tx_packet, 4'd0);
        check("reset busy", busy, 1'b0);
        check("reset toggle", cur_toggle, 1'b0);
        check("reset pulses", {hs_grant, data_grant, xfer_done, xfer_err}, 4'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        check("idle without request", {busy, tx_packet}, 5'd0);

        for (int i = 0; i < 12; i++) begin
            run_xfer(vecs[i].is_hs, vecs[i].htype, !vecs[i].is_hs, vecs[i].has_act,
                     vecs[i].d, vecs[i].len, vecs[i].err_rel, 1);
            check_xfer($sformatf("vec%0d", i), vecs[i].is_hs, vecs[i].exp_pid,
                       vecs[i].exp_ok, vecs[i].exp_f, vecs[i].exp_att);
            post_actions(vecs[i].n_ack, vecs[i].treset);
            check($sformatf("vec%0d toggle", i), cur_toggle, vecs[i].exp_tog);
        end
        m_tog    = vecs[11].exp_tog;
        m_ack_ok = 1'b0;

        // STALL and data requested together: handshake first, data after one IDLE cycle.
        run_xfer(1'b1, 2'd2, 1'b1, 1'b1, 0, 3, 0, 2);
        check("prio finished", timed_out, 1'b0);
        check("prio issue count", n_iss, 2);
        if (n_iss == 2 && n_end == 2) begin
            check("prio first pid", iss_pid[0], 4'd5);
            check("prio first grant", {iss_hg[0], iss_dg[0]}, 2'b10);
            check("prio first done", {end_ok[0], 32'(end_cyc[0])}, {1'b1, 32'd6});
            check("prio second pid", iss_pid[1], m_tog ? 4'd2 : 4'd1);
            check("prio second grant", {iss_hg[1], iss_dg[1]}, 2'b01);
            check("prio idle gap", iss_cyc[1] - end_cyc[0], 2);
            check("prio second done", {end_ok[1], 32'(end_cyc[1])}, {1'b1, 32'd13});
        end
        post_actions(1, 1'b0);
        m_tog    = !m_tog;
        m_ack_ok = 1'b0;
        check("prio toggle", cur_toggle, m_tog);

        random_phase();
        reset_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
